// File: rtl/bpd_table_ram_if.sv
// Request/response bundle for one predictor table: a valid/ready request channel
// and a one-cycle-later read response channel.
interface bpd_table_ram_if #(
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 9
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_wdata;
    logic [WIDTH-1:0]  req_wmask;
    logic              rsp_valid;
    logic [WIDTH-1:0]  rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/bpd_table_ram.sv
// Single-port branch-predictor table with masked writes, registered reads and an init sweep.
// Optional BPD_TABLE_RDATA_HOLD_EN: rsp_rdata keeps the last read value between responses.
module bpd_table_ram #(
    parameter int               DEPTH    = 256,
    parameter int               WIDTH    = 9,
    parameter int               ADDR_W   = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    bpd_table_ram_if.slave      bus,
    input  logic                flush,
    output logic                init_busy
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Widened by one bit so the range compare stays meaningful for power-of-two depths.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              acc;
    logic              in_range;
    logic              wr_acc;
    logic              rd_acc;
    logic [WIDTH-1:0]  rd_word;

    logic              rsp_vld_p1;
    logic [WIDTH-1:0]  rsp_data_p1;

    function automatic logic [WIDTH-1:0] merge_masked(
        input logic [WIDTH-1:0] old_word,
        input logic [WIDTH-1:0] wdata,
        input logic [WIDTH-1:0] wmask
    );
        return (old_word & ~wmask) | (wdata & wmask);
    endfunction

    assign bus.req_ready = (state == RUN);
    assign init_busy     = (state == INIT);

    always_comb begin
        in_range = ({1'b0, bus.req_addr} < DEPTH_EXT);
        acc      = bus.req_valid && bus.req_ready;
        wr_acc   = acc && bus.req_write;
        rd_acc   = acc && !bus.req_write;
        rd_word  = INIT_VAL;
        if (in_range) begin
            rd_word = mem[bus.req_addr];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    if (flush) begin
                        ptr <= '0;
                    end else if (ptr == LAST_IDX) begin
                        state <= RUN;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= INIT;
                        ptr   <= '0;
                    end
                end
                default: begin
                    state <= INIT;
                    ptr   <= '0;
                end
            endcase
        end
    end

    // Storage: sweep owns the port during INIT, requests own it during RUN.
    always_ff @(posedge clock) begin
        if (state == INIT) begin
            mem[ptr] <= INIT_VAL;
        end else if (wr_acc && in_range) begin
            mem[bus.req_addr] <= merge_masked(rd_word, bus.req_wdata, bus.req_wmask);
        end
    end

    // Stage p1: registered read response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_vld_p1  <= 1'b0;
            rsp_data_p1 <= '0;
        end else begin
            rsp_vld_p1 <= rd_acc;
`ifdef BPD_TABLE_RDATA_HOLD_EN
            if (rd_acc) begin
                rsp_data_p1 <= rd_word;
            end
`else
            rsp_data_p1 <= rd_acc ? rd_word : '0;
`endif
        end
    end

    assign bus.rsp_valid = rsp_vld_p1;
    assign bus.rsp_rdata = rsp_data_p1;

endmodule

// File: tb/tb_bpd_table_ram.sv
// Scoreboard bench for bpd_table_ram: a 256-entry and a 200-entry instance side by side.
module tb_bpd_table_ram;

    localparam logic [8:0] INIT_A  = 9'h0A5;
    localparam logic [8:0] INIT_B  = 9'h03C;
    localparam int         DEPTH_A = 256;
    localparam int         DEPTH_B = 200;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_a, rst_b, flush_a, flush_b, busy_a, busy_b;

    bpd_table_ram_if #(.ADDR_W(8), .WIDTH(9)) bus_a ();
    bpd_table_ram_if #(.ADDR_W(8), .WIDTH(9)) bus_b ();

    bpd_table_ram #(.DEPTH(DEPTH_A), .WIDTH(9), .INIT_VAL(INIT_A)) u_dut_a (
        .clock(clock), .reset_n(rst_a), .bus(bus_a), .flush(flush_a), .init_busy(busy_a)
    );
    bpd_table_ram #(.DEPTH(DEPTH_B), .WIDTH(9), .INIT_VAL(INIT_B)) u_dut_b (
        .clock(clock), .reset_n(rst_b), .bus(bus_b), .flush(flush_b), .init_busy(busy_b)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [8:0] q_a[$];
    logic [8:0] q_b[$];
    logic [8:0] model[2][256];
    logic [8:0] last_rd[2];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic sb_step(input int id, input logic rn, input logic rv, input logic [8:0] rd,
                           input logic vld, input logic rdy, input logic wr, input logic [7:0] a,
                           input logic [8:0] wd, input logic [8:0] wm, input logic fl);
        int         depth;
        logic [8:0] iv;
        logic [8:0] e;
        depth = (id == 0) ? DEPTH_A : DEPTH_B;
        iv    = (id == 0) ? INIT_A : INIT_B;
        if (!rn) return;
        if (rv) begin
            if (((id == 0) ? q_a.size() : q_b.size()) == 0) begin
                check_val("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
                check_val("rsp_rdata", {23'd0, rd}, {23'd0, e});
                last_rd[id] = e;
            end
        end else begin
`ifdef BPD_TABLE_RDATA_HOLD_EN
            check_val("idle_rdata", {23'd0, rd}, {23'd0, last_rd[id]});
`else
            check_val("idle_rdata", {23'd0, rd}, 32'd0);
`endif
        end
        if (vld && rdy) begin
            if (wr) begin
                if (int'(a) < depth) model[id][a] = (model[id][a] & ~wm) | (wd & wm);
            end else begin
                e = (int'(a) < depth) ? model[id][a] : iv;
                if (id == 0) q_a.push_back(e);
                else q_b.push_back(e);
            end
        end
        if (fl) begin
            for (int i = 0; i < 256; i++) model[id][i] = iv;
        end
    endtask

    always @(negedge clock) begin
        sb_step(0, rst_a, bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.req_valid, bus_a.req_ready,
                bus_a.req_write, bus_a.req_addr, bus_a.req_wdata, bus_a.req_wmask, flush_a);
        sb_step(1, rst_b, bus_b.rsp_valid, bus_b.rsp_rdata, bus_b.req_valid, bus_b.req_ready,
                bus_b.req_write, bus_b.req_addr, bus_b.req_wdata, bus_b.req_wmask, flush_b);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input int id, input logic v, input logic w, input logic [7:0] a,
                             input logic [8:0] d, input logic [8:0] m);
        if (id == 0) begin
            bus_a.req_valid = v; bus_a.req_write = w; bus_a.req_addr = a;
            bus_a.req_wdata = d; bus_a.req_wmask = m;
        end else begin
            bus_b.req_valid = v; bus_b.req_write = w; bus_b.req_addr = a;
            bus_b.req_wdata = d; bus_b.req_wmask = m;
        end
    endtask

    task automatic idle(input int id);
        drive_req(id, 1'b0, 1'b0, 8'd0, 9'd0, 9'd0);
    endtask

    task automatic model_clear(input int id);
        for (int i = 0; i < 256; i++) model[id][i] = (id == 0) ? INIT_A : INIT_B;
        last_rd[id] = '0;
        if (id == 0) q_a.delete();
        else q_b.delete();
    endtask

    task automatic wait_init(input int id, input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (((id == 0) ? busy_a : busy_b) && n < 2000) begin
            tick();
            n++;
        end
        check_val(tag, n, exp_cycles);
    endtask

    task automatic read_expect(input int id, input logic [7:0] a, input logic [8:0] expv,
                               input string tag);
        drive_req(id, 1'b1, 1'b0, a, 9'd0, 9'd0);
        tick();
        idle(id);
        check_val({tag, "_vld"}, (id == 0) ? bus_a.rsp_valid : bus_b.rsp_valid, 32'd1);
        check_val(tag, (id == 0) ? bus_a.rsp_rdata : bus_b.rsp_rdata, {23'd0, expv});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, bus_a.req_ready, 32'd0);
        check_val({tag, "_busy"}, busy_a, 32'd1);
        check_val({tag, "_rsp_vld"}, bus_a.rsp_valid, 32'd0);
        check_val({tag, "_rsp_data"}, bus_a.rsp_rdata, 32'd0);
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
        idle(0); idle(1);
        model_clear(0); model_clear(1);
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_a = 1'b1; rst_b = 1'b1;
        wait_init(0, "init_cycles_a", DEPTH_A);
        check_val("ready_a_run", bus_a.req_ready, 32'd1);
        check_val("busy_b_done", busy_b, 32'd0);

        // Initial contents, back-to-back reads.
        drive_req(0, 1'b1, 1'b0, 8'd0, 9'd0, 9'd0);   tick();
        drive_req(0, 1'b1, 1'b0, 8'd128, 9'd0, 9'd0); tick();
        drive_req(0, 1'b1, 1'b0, 8'd255, 9'd0, 9'd0); tick();
        idle(0);
        check_val("rd255_vld", bus_a.rsp_valid, 32'd1);
        check_val("rd255", bus_a.rsp_rdata, {23'd0, INIT_A});
        repeat (2) tick();

        // Masked write then read.
        drive_req(0, 1'b1, 1'b1, 8'd3, 9'h1FF, 9'h00F); tick();
        read_expect(0, 8'd3, 9'h0AF, "masked_rd3");

        // Write immediately followed by read of the same entry.
        drive_req(0, 1'b1, 1'b1, 8'd7, 9'h155, 9'h1FF); tick();
        check_val("ready_b2b", bus_a.req_ready, 32'd1);
        read_expect(0, 8'd7, 9'h155, "b2b_rd7");
        tick();
`ifdef BPD_TABLE_RDATA_HOLD_EN
        check_val("hold_rdata", bus_a.rsp_rdata, 32'h155);
`else
        check_val("zero_rdata", bus_a.rsp_rdata, 32'h0);
`endif

        // Out-of-range write on the 200-entry table is dropped.
        drive_req(1, 1'b1, 1'b1, 8'd250, 9'h1FF, 9'h1FF); tick();
        read_expect(1, 8'd250, INIT_B, "oor_rd250");
        read_expect(1, 8'd199, INIT_B, "oor_rd199");
        read_expect(1, 8'd50, INIT_B, "oor_rd50");
        read_expect(1, 8'd122, INIT_B, "oor_rd122");
        tick();

        // Flush together with an accepted read.
        drive_req(0, 1'b1, 1'b0, 8'd7, 9'd0, 9'd0);
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        idle(0);
        check_val("flush_rd_vld", bus_a.rsp_valid, 32'd1);
        check_val("flush_rd7", bus_a.rsp_rdata, 32'h155);
        check_val("flush_busy", busy_a, 32'd1);
        check_val("flush_ready", bus_a.req_ready, 32'd0);
        wait_init(0, "flush_init_cycles", DEPTH_A);
        read_expect(0, 8'd7, INIT_A, "post_flush_rd7");
        tick();

        // Flush restarts a sweep already in progress.
        flush_a = 1'b1; tick(); flush_a = 1'b0;
        repeat (50) tick();
        flush_a = 1'b1; tick(); flush_a = 1'b0;
        wait_init(0, "reflush_init_cycles", DEPTH_A);

        // Reset in the middle of a sweep.
        flush_a = 1'b1; tick(); flush_a = 1'b0;
        repeat (20) tick();
        rst_a = 1'b0;
        model_clear(0);
        #1;
        check_reset_outputs("rst_sweep");
        tick();
        rst_a = 1'b1;
        wait_init(0, "rst_sweep_init_cycles", DEPTH_A);

        // Reset while a read response is on the bus.
        drive_req(0, 1'b1, 1'b1, 8'd5, 9'h1AB, 9'h1FF); tick();
        drive_req(0, 1'b1, 1'b0, 8'd5, 9'd0, 9'd0);     tick();
        idle(0);
        check_val("pre_rst_vld", bus_a.rsp_valid, 32'd1);
        check_val("pre_rst_rd5", bus_a.rsp_rdata, 32'h1AB);
        rst_a = 1'b0;
        model_clear(0);
        #1;
        check_reset_outputs("rst_read");
        repeat (2) tick();
        rst_a = 1'b1;
        wait_init(0, "rst_read_init_cycles", DEPTH_A);
        read_expect(0, 8'd5, INIT_A, "post_rst_rd5");
        repeat (3) tick();

        check_val("q_a_empty", q_a.size(), 32'd0);
        check_val("q_b_empty", q_b.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
